// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// The build option MEM_ARB_ROUND_ROBIN_EN is consumed by mem_port_arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Owner codes double as bit positions in the request/grant vectors
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } mem_port_t;

  // Highest legal byte address for a memory of 'words' 32-bit words
  function automatic logic [ADDR_W-1:0] range_limit(input int unsigned words);
    return ADDR_W'(words * 32'd4 - 32'd4);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for port connection.
// slave: arbiter view; master: requesters plus memory view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              iwIReq;
  logic [ADDR_W-1:0] iwIAddr;
  logic              owIGnt;
  logic              owIRvalid;
  logic [DATA_W-1:0] owIRdata;

  logic              iwDReq;
  logic [ADDR_W-1:0] iwDAddr;
  logic [DATA_W-1:0] iwDWdata;
  logic [STRB_W-1:0] iwDWstrb;
  logic              owDGnt;
  logic              owDRvalid;
  logic [DATA_W-1:0] owDRdata;

  logic              owError;

  logic [ADDR_W-1:0] owMemReadAddr;
  logic [ADDR_W-1:0] owMemWriteAddr;
  logic [DATA_W-1:0] owMemWriteData;
  logic [STRB_W-1:0] owMemWstrb;
  logic [DATA_W-1:0] iwMemReadData;

  modport slave (
    input  iwIReq, iwIAddr, iwDReq, iwDAddr, iwDWdata, iwDWstrb, iwMemReadData,
    output owIGnt, owIRvalid, owIRdata, owDGnt, owDRvalid, owDRdata, owError,
    output owMemReadAddr, owMemWriteAddr, owMemWriteData, owMemWstrb
  );

  modport master (
    output iwIReq, iwIAddr, iwDReq, iwDAddr, iwDWdata, iwDWstrb, iwMemReadData,
    input  owIGnt, owIRvalid, owIRdata, owDGnt, owDRvalid, owDRdata, owError,
    input  owMemReadAddr, owMemWriteAddr, owMemWriteData, owMemWstrb
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker: one-hot grant from requests and a priority pointer.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] iwReq,
  input  logic       iwPtr,
  output logic [1:0] owGnt
);

  // D wins when alone or when it holds priority; otherwise I takes it
  always_comb begin
    owGnt = 2'b00;
    if (iwReq[OWN_D] && (!iwReq[OWN_I] || (iwPtr == OWN_D))) begin
      owGnt[OWN_D] = 1'b1;
    end else if (iwReq[OWN_I]) begin
      owGnt[OWN_I] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported byte memory between instruction fetch (I) and load/store (D).
// MEM_ARB_ROUND_ROBIN_EN selects round-robin contention; undefined gives fixed D-over-I priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned pWords = 32'd44
) (
  input  logic               iwClk,
  input  logic               iwnRst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = range_limit(pWords);

  state_t            state_q;
  logic              owner_q;
  logic              store_q;
  logic              err_q;
  logic              rvalid_i_q;
  logic              rvalid_d_q;
  mem_port_t         last_q;

  logic              ptr;
  logic              idle_c;
  logic [1:0]        req_c;
  logic [1:0]        pick_c;
  logic              gnt_i_c;
  logic              gnt_d_c;
  logic              any_gnt_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic              legal_c;
  logic              store_c;
  mem_port_t         mem_c;
  logic [STRB_W-1:0] wstrb_c;

  // Grants only in IDLE and never while reset is held
  assign idle_c = (state_q == ST_IDLE) && iwnRst;
  assign req_c  = {bus.iwDReq, bus.iwIReq} & {2{idle_c}};

  mem_arb_pick u_pick (
    .iwReq (req_c),
    .iwPtr (ptr),
    .owGnt (pick_c)
  );

  assign gnt_i_c    = pick_c[OWN_I];
  assign gnt_d_c    = pick_c[OWN_D];
  assign any_gnt_c  = gnt_i_c | gnt_d_c;
  assign sel_addr_c = gnt_d_c ? bus.iwDAddr : bus.iwIAddr;
  assign legal_c    = (sel_addr_c <= ADDR_LIMIT);
  assign store_c    = gnt_d_c && (bus.iwDWstrb != '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Priority moves to whichever requester was not just granted
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      ptr <= OWN_D;
    end else if (any_gnt_c) begin
      ptr <= gnt_d_c ? OWN_I : OWN_D;
    end
  end
`else
  assign ptr = OWN_D;
`endif

  // Memory ports follow the winner in its grant cycle and hold otherwise
  always_comb begin
    mem_c   = last_q;
    wstrb_c = '0;
    if (gnt_i_c) begin
      mem_c.raddr = bus.iwIAddr;
    end
    if (gnt_d_c) begin
      mem_c.raddr = bus.iwDAddr;
      if (store_c) begin
        mem_c.waddr = bus.iwDAddr;
        mem_c.wdata = bus.iwDWdata;
        if (legal_c) begin
          wstrb_c = bus.iwDWstrb;
        end
      end
    end
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
      rvalid_i_q <= 1'b0;
      rvalid_d_q <= 1'b0;
      last_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rvalid_i_q <= gnt_i_c;
          rvalid_d_q <= gnt_d_c;
          err_q      <= any_gnt_c && !legal_c;
          if (any_gnt_c) begin
            owner_q <= gnt_d_c ? OWN_D : OWN_I;
            store_q <= store_c;
            last_q  <= mem_c;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          rvalid_i_q <= 1'b0;
          rvalid_d_q <= 1'b0;
          err_q      <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.owIGnt    = gnt_i_c;
  assign bus.owDGnt    = gnt_d_c;
  assign bus.owIRvalid = rvalid_i_q;
  assign bus.owDRvalid = rvalid_d_q;
  assign bus.owError   = err_q;

  // Read data comes straight from the memory's output register in RESP
  assign bus.owIRdata = ((state_q == ST_RESP) && (owner_q == OWN_I) && !err_q)
                        ? bus.iwMemReadData : '0;
  assign bus.owDRdata = ((state_q == ST_RESP) && (owner_q == OWN_D) && !err_q && !store_q)
                        ? bus.iwMemReadData : '0;

  assign bus.owMemReadAddr  = mem_c.raddr;
  assign bus.owMemWriteAddr = mem_c.waddr;
  assign bus.owMemWriteData = mem_c.wdata;
  assign bus.owMemWstrb     = wstrb_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read byte memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned WORDS = 44;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.pWords(WORDS)) dut (
    .iwClk  (clk),
    .iwnRst (rst_n),
    .bus    (bus)
  );

  // Memory model: word k initialises to A5A5_00kk, read data registered
  logic [31:0] mem [WORDS];
  logic [31:0] mem_rdata_q;
  assign bus.iwMemReadData = mem_rdata_q;

  always @(posedge clk) begin
    int unsigned ridx;
    int unsigned widx;
    if (!rst_n) begin
      for (int k = 0; k < int'(WORDS); k++) mem[k] <= 32'hA5A50000 | 32'(k);
      mem_rdata_q <= '0;
    end else begin
      ridx = 32'(bus.owMemReadAddr[31:2]);
      widx = 32'(bus.owMemWriteAddr[31:2]);
      mem_rdata_q <= (ridx < WORDS) ? mem[ridx] : 32'h0;
      if (widx < WORDS) begin
        for (int b = 0; b < 4; b++)
          if (bus.owMemWstrb[b]) mem[widx][8*b +: 8] <= bus.owMemWriteData[8*b +: 8];
      end
    end
  end

  task automatic drop_reqs();
    bus.iwIReq   = 1'b0;
    bus.iwDReq   = 1'b0;
    bus.iwDWstrb = 4'h0;
  endtask

  task automatic test_reset();
    logic [3:0]  got4;
    logic [99:0] got100;
    rst_n        = 1'b0;
    bus.iwIReq   = 1'b1;
    bus.iwIAddr  = 32'h10;
    bus.iwDReq   = 1'b1;
    bus.iwDAddr  = 32'h20;
    bus.iwDWdata = 32'h12345678;
    bus.iwDWstrb = 4'hF;
    repeat (2) @(negedge clk);
    got4 = {bus.owIGnt, bus.owDGnt, bus.owIRvalid, bus.owDRvalid};
    n_cmp++;
    if (got4 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_handshake got %b want 0000", got4);
    end
    n_cmp++;
    if (bus.owError !== 1'b0) begin
      n_fail++; $display("FAIL reset_error got %b want 0", bus.owError);
    end
    got100 = {bus.owMemReadAddr, bus.owMemWriteAddr, bus.owMemWriteData, bus.owMemWstrb};
    n_cmp++;
    if (got100 !== 100'h0) begin
      n_fail++; $display("FAIL reset_mem_outputs got %h want 0", got100);
    end
    drop_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [37:0] g;
    logic [34:0] r;
    @(posedge clk); #1;
    bus.iwIReq  = 1'b1;
    bus.iwIAddr = 32'h0;
    @(negedge clk);
    g = {bus.owIGnt, bus.owDGnt, bus.owMemWstrb, bus.owMemReadAddr};
    n_cmp++;
    if (g !== {1'b1, 1'b0, 4'h0, 32'h0}) begin
      n_fail++; $display("FAIL fetch_grant got %h want %h", g, {1'b1, 1'b0, 4'h0, 32'h0});
    end
    @(posedge clk); #1;
    bus.iwIReq  = 1'b0;
    bus.iwIAddr = 32'h40;
    @(negedge clk);
    r = {bus.owIRvalid, bus.owDRvalid, bus.owError, bus.owIRdata};
    n_cmp++;
    if (r !== {3'b100, 32'hA5A50000}) begin
      n_fail++; $display("FAIL fetch_resp got %h want %h", r, {3'b100, 32'hA5A50000});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.owIRvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rvalid_pulse got %b want 0", bus.owIRvalid);
    end
  endtask

  task automatic test_store_load();
    logic [101:0] g;
    logic [38:0]  r;
    logic [37:0]  lg;
    logic [33:0]  lr;
    @(posedge clk); #1;
    bus.iwDReq   = 1'b1;
    bus.iwDAddr  = 32'd8;
    bus.iwDWdata = 32'hDEADBEEF;
    bus.iwDWstrb = 4'b0011;
    @(negedge clk);
    g = {bus.owDGnt, bus.owIGnt, bus.owMemWstrb, bus.owMemWriteAddr, bus.owMemReadAddr, bus.owMemWriteData};
    n_cmp++;
    if (g !== {1'b1, 1'b0, 4'b0011, 32'd8, 32'd8, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL store_grant got %h want %h", g, {1'b1, 1'b0, 4'b0011, 32'd8, 32'd8, 32'hDEADBEEF});
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    r = {bus.owDRvalid, bus.owIRvalid, bus.owError, bus.owDRdata, bus.owMemWstrb};
    n_cmp++;
    if (r !== {3'b100, 32'h0, 4'h0}) begin
      n_fail++; $display("FAIL store_resp got %h want %h", r, {3'b100, 32'h0, 4'h0});
    end
    @(posedge clk); #1;
    bus.iwDReq  = 1'b1;
    bus.iwDAddr = 32'd8;
    @(negedge clk);
    lg = {bus.owDGnt, bus.owIGnt, bus.owMemWstrb, bus.owMemReadAddr};
    n_cmp++;
    if (lg !== {2'b10, 4'h0, 32'd8}) begin
      n_fail++; $display("FAIL load_grant got %h want %h", lg, {2'b10, 4'h0, 32'd8});
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    lr = {bus.owDRvalid, bus.owError, bus.owDRdata};
    n_cmp++;
    if (lr !== {2'b10, 32'hA5A5BEEF}) begin
      n_fail++; $display("FAIL load_after_store got %h want %h", lr, {2'b10, 32'hA5A5BEEF});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_h [6];
    logic [3:0] h;
    // Fetch first so the round-robin pointer starts at D
    @(posedge clk); #1;
    bus.iwIReq  = 1'b1;
    bus.iwIAddr = 32'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.owIGnt !== 1'b1) begin
      n_fail++; $display("FAIL prefetch_grant got %b want 1", bus.owIGnt);
    end
    @(posedge clk); #1;
    bus.iwIReq = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.owIRdata !== 32'hA5A50001) begin
      n_fail++; $display("FAIL prefetch_data got %h want a5a50001", bus.owIRdata);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_h = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
`else
    exp_h = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
`endif
    @(posedge clk); #1;
    bus.iwIReq   = 1'b1;
    bus.iwIAddr  = 32'd4;
    bus.iwDReq   = 1'b1;
    bus.iwDAddr  = 32'd12;
    bus.iwDWstrb = 4'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      h = {bus.owIGnt, bus.owDGnt, bus.owIRvalid, bus.owDRvalid};
      n_cmp++;
      if (h !== exp_h[c]) begin
        n_fail++; $display("FAIL contention_cycle%0d got %b want %b", c, h, exp_h[c]);
      end
      if (c == 1) begin
        n_cmp++;
        if (bus.owDRdata !== 32'hA5A50003) begin
          n_fail++; $display("FAIL contention_ddata got %h want a5a50003", bus.owDRdata);
        end
      end
    end
    @(posedge clk); #1;
    drop_reqs();
  endtask

  task automatic test_range();
    logic [31:0] addrs [4];
    logic [3:0]  strbs [4];
    logic        is_i  [4];
    logic        err_x [4];
    logic [31:0] dat_x [4];
    logic [4:0]  g;
    logic [33:0] r;
    addrs = '{32'd176, 32'd176, 32'hFFFFFFFF, 32'd172};
    strbs = '{4'h0, 4'hF, 4'h0, 4'h0};
    is_i  = '{1'b0, 1'b0, 1'b1, 1'b0};
    err_x = '{1'b1, 1'b1, 1'b1, 1'b0};
    dat_x = '{32'h0, 32'h0, 32'h0, 32'hA5A5002B};
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      if (is_i[t]) begin
        bus.iwIReq  = 1'b1;
        bus.iwIAddr = addrs[t];
      end else begin
        bus.iwDReq   = 1'b1;
        bus.iwDAddr  = addrs[t];
        bus.iwDWdata = 32'h12345678;
        bus.iwDWstrb = strbs[t];
      end
      @(negedge clk);
      g = {(is_i[t] ? bus.owIGnt : bus.owDGnt), bus.owMemWstrb};
      n_cmp++;
      if (g !== 5'b10000) begin
        n_fail++; $display("FAIL range%0d_grant got %b want 10000", t, g);
      end
      @(posedge clk); #1;
      drop_reqs();
      @(negedge clk);
      r = is_i[t] ? {bus.owIRvalid, bus.owError, bus.owIRdata}
                  : {bus.owDRvalid, bus.owError, bus.owDRdata};
      n_cmp++;
      if (r !== {1'b1, err_x[t], dat_x[t]}) begin
        n_fail++; $display("FAIL range%0d_resp got %h want %h", t, r, {1'b1, err_x[t], dat_x[t]});
      end
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [2:0]  v;
    logic [1:0]  g;
    logic [32:0] r;
    @(posedge clk); #1;
    bus.iwDReq  = 1'b1;
    bus.iwDAddr = 32'd0;
    @(negedge clk);
    n_cmp++;
    if (bus.owDGnt !== 1'b1) begin
      n_fail++; $display("FAIL midrst_grant got %b want 1", bus.owDGnt);
    end
    @(posedge clk); #1;
    drop_reqs();
    n_cmp++;
    if (bus.owDRvalid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pending got %b want 1", bus.owDRvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    v = {bus.owIRvalid, bus.owDRvalid, bus.owError};
    n_cmp++;
    if (v !== 3'b000) begin
      n_fail++; $display("FAIL midrst_rvalid_cleared got %b want 000", v);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.owDRvalid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_no_replay%0d got %b want 0", c, bus.owDRvalid);
      end
    end
    @(posedge clk); #1;
    bus.iwIReq   = 1'b1;
    bus.iwIAddr  = 32'd4;
    bus.iwDReq   = 1'b1;
    bus.iwDAddr  = 32'd12;
    bus.iwDWstrb = 4'h0;
    @(negedge clk);
    g = {bus.owIGnt, bus.owDGnt};
    n_cmp++;
    if (g !== 2'b01) begin
      n_fail++; $display("FAIL postrst_first_grant got %b want 01", g);
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    r = {bus.owDRvalid, bus.owDRdata};
    n_cmp++;
    if (r !== {1'b1, 32'hA5A50003}) begin
      n_fail++; $display("FAIL postrst_resp got %h want %h", r, {1'b1, 32'hA5A50003});
    end
  endtask

  initial begin
    bus.iwIAddr  = '0;
    bus.iwDAddr  = '0;
    bus.iwDWdata = '0;
    drop_reqs();
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_range();
    test_reset_mid_resp();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
